// File: rtl/axil_bridge_pkg.sv
// Shared types and AXI4-Lite response codes for the CPU-to-AXI4-Lite master bridge.
package axil_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_RSP
   } axil_br_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int REQ_ADDR_W = 32;

   typedef struct packed {
      logic [REQ_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
      logic [3:0]            wstrb;
      logic                  we;
   } axil_br_req_t;

   // Both error codes report as a single error bit toward the CPU.
   function automatic logic resp_is_err(input logic [1:0] resp);
      logic err;
      err = 1'b0;
      case (resp)
         RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
         RESP_SLVERR, RESP_DECERR: err = 1'b1;
         default:                  err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding CPU load/store bus to AXI4-Lite master bridge.
// Optional address window check enabled by defining AXIL_BRIDGE_RANGE_CHECK_EN.
module axil_master_bridge
   import axil_bridge_pkg::*;
#(
   parameter int          ADDR_W     = 32,
   parameter logic [2:0]  PROT       = 3'b000,
   parameter logic [31:0] RANGE_BASE = 32'h0000_0000,
   parameter logic [31:0] RANGE_SIZE = 32'h0000_0010
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] M_AXI_AWADDR,
   output logic [2:0]        M_AXI_AWPROT,
   output logic              M_AXI_AWVALID,
   input  logic              M_AXI_AWREADY,
   output logic [31:0]       M_AXI_WDATA,
   output logic [3:0]        M_AXI_WSTRB,
   output logic              M_AXI_WVALID,
   input  logic              M_AXI_WREADY,
   input  logic [1:0]        M_AXI_BRESP,
   input  logic              M_AXI_BVALID,
   output logic              M_AXI_BREADY,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic [2:0]        M_AXI_ARPROT,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic [31:0]       M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY
);

   axil_br_state_t    state_q, state_d;
   axil_br_req_t      req_q;
   logic              aw_done_q, w_done_q;
   logic [ADDR_W-1:0] req_addr_al;
   logic              accept, range_err, aw_fire, w_fire, rsp_capture;

   // Bus accesses are word-sized, so the byte offset is dropped on capture.
   assign req_addr_al = req_addr & ~ADDR_W'(3);
   assign accept      = req_valid && (state_q == ST_IDLE);

`ifdef AXIL_BRIDGE_RANGE_CHECK_EN
   logic [63:0] addr_ext;
   assign addr_ext  = 64'(req_addr_al);
   assign range_err = (addr_ext < 64'(RANGE_BASE)) ||
                      (addr_ext >= (64'(RANGE_BASE) + 64'(RANGE_SIZE)));
`else
   assign range_err = 1'b0;
`endif

   assign req_ready     = (state_q == ST_IDLE);
   assign rsp_valid     = (state_q == ST_RSP);
   assign M_AXI_AWADDR  = ADDR_W'(req_q.addr);
   assign M_AXI_ARADDR  = ADDR_W'(req_q.addr);
   assign M_AXI_AWPROT  = PROT;
   assign M_AXI_ARPROT  = PROT;
   assign M_AXI_WDATA   = req_q.wdata;
   assign M_AXI_WSTRB   = req_q.wstrb;
   assign M_AXI_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
   assign M_AXI_WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
   assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
   assign M_AXI_ARVALID = (state_q == ST_RD_REQ);
   assign M_AXI_RREADY  = (state_q == ST_RD_RESP);

   assign aw_fire     = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_fire      = M_AXI_WVALID && M_AXI_WREADY;
   assign rsp_capture = (M_AXI_BREADY && M_AXI_BVALID) || (M_AXI_RREADY && M_AXI_RVALID);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // AW and W may complete in either order; leave once both have handshaken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (accept) begin
               if (range_err)   state_d = ST_RSP;
               else if (req_we) state_d = ST_WR_REQ;
               else             state_d = ST_RD_REQ;
            end
         ST_WR_REQ:
            if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_WR_RESP;
         ST_WR_RESP:
            if (M_AXI_BVALID) state_d = ST_RSP;
         ST_RD_REQ:
            if (M_AXI_ARREADY) state_d = ST_RD_RESP;
         ST_RD_RESP:
            if (M_AXI_RVALID) state_d = ST_RSP;
         ST_RSP:
            state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   // Response fields persist after the pulse until the next response overwrites them.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         req_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            req_q     <= '{addr: REQ_ADDR_W'(req_addr_al), wdata: req_wdata,
                           wstrb: req_wstrb, we: req_we};
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (range_err) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b1;
            end
         end
         if (aw_fire) aw_done_q <= 1'b1;
         if (w_fire)  w_done_q  <= 1'b1;
         if (rsp_capture) begin
            rsp_rdata <= req_q.we ? 32'h0 : M_AXI_RDATA;
            rsp_err   <= resp_is_err(req_q.we ? M_AXI_BRESP : M_AXI_RRESP);
         end
      end
   end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge with a small 4-word AXI4-Lite slave model.
module tb_axil_master_bridge;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_wstrb = 4'hF;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [2:0]  AWPROT, ARPROT;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [1:0]  BRESP, RRESP;

   int errors = 0;
   int checks = 0;

   int          aw_delay = 0;
   logic        ar_block = 1'b0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic        rdata_force = 1'b0;
   logic [31:0] rdata_val = '0;

   int          aw_wait;
   logic        have_aw, have_w;
   logic [31:0] aw_addr_q, w_data_q, wa, wd;
   logic [31:0] mem [4];
   int          bready_cnt = 0;
   int          arvalid_cnt = 0;

   always #5 ACLK = ~ACLK;

   axil_master_bridge dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
      .M_AXI_AWREADY(AWREADY),
      .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
      .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
      .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID),
      .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
   );

   assign AWREADY = (aw_wait >= aw_delay);
   assign WREADY  = 1'b1;
   assign ARREADY = !ar_block;

   // Slave model: responds the cycle after the address/data handshakes complete.
   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_wait <= 0; have_aw <= 1'b0; have_w <= 1'b0;
         BVALID <= 1'b0; RVALID <= 1'b0; BRESP <= 2'b00; RRESP <= 2'b00; RDATA <= '0;
         aw_addr_q <= '0; w_data_q <= '0;
      end else begin
         if (AWVALID && AWREADY) aw_wait <= 0;
         else if (AWVALID)       aw_wait <= aw_wait + 1;
         wa = (AWVALID && AWREADY) ? AWADDR : aw_addr_q;
         wd = (WVALID && WREADY) ? WDATA : w_data_q;
         if (AWVALID && AWREADY) begin have_aw <= 1'b1; aw_addr_q <= AWADDR; end
         if (WVALID && WREADY)   begin have_w <= 1'b1;  w_data_q <= WDATA;   end
         if (BVALID && BREADY) BVALID <= 1'b0;
         if ((have_aw || (AWVALID && AWREADY)) && (have_w || (WVALID && WREADY)) && !BVALID) begin
            BVALID <= 1'b1;
            BRESP  <= bresp_cfg;
            mem[wa[3:2]] <= wd;
            have_aw <= 1'b0;
            have_w  <= 1'b0;
         end
         if (RVALID && RREADY) RVALID <= 1'b0;
         if (ARVALID && ARREADY) begin
            RVALID <= 1'b1;
            RRESP  <= rresp_cfg;
            RDATA  <= rdata_force ? rdata_val : mem[ARADDR[3:2]];
         end
      end
   end

   always @(negedge ACLK) begin
      if (BREADY)  bready_cnt  <= bready_cnt + 1;
      if (ARVALID) arvalid_cnt <= arvalid_cnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Presents a request and returns at the falling edge of the first cycle after acceptance.
   task automatic startReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      @(negedge ACLK);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = 4'hF;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      if (!req_ready) checkOutput("accept_timeout", {31'h0, req_ready}, 32'h1);
      @(negedge ACLK);
      req_valid = 1'b0;
   endtask

   task automatic waitRsp(output int lat, output logic [31:0] rd, output logic er, output logic leak);
      lat = 1;
      leak = 1'b0;
      while (!rsp_valid && lat < 50) begin
         if (req_ready) leak = 1'b1;
         @(negedge ACLK);
         lat++;
      end
      if (!rsp_valid) checkOutput("rsp_timeout", {31'h0, rsp_valid}, 32'h1);
      rd = rsp_rdata;
      er = rsp_err;
   endtask

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                output int lat, output logic [31:0] rd, output logic er,
                                output logic leak);
      startReq(we, addr, wdata);
      waitRsp(lat, rd, er, leak);
   endtask

   initial begin
      int          lat, b0, a0;
      logic [31:0] rd;
      logic        er, leak;

      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      $display("[TB] reset values");
      checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("rst_valids", {27'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'h0);
      checkOutput("rst_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
      checkOutput("rst_rdata", rsp_rdata, 32'h0);

      $display("[TB] write then read back four registers");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'(i * 4), 32'(i + 1), lat, rd, er, leak);
         checkOutput($sformatf("wr%0d_err", i), {31'h0, er}, 32'h0);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'(i * 4), 32'h0, lat, rd, er, leak);
         checkOutput($sformatf("rd%0d_data", i), rd, 32'(i + 1));
         checkOutput($sformatf("rd%0d_err", i), {31'h0, er}, 32'h0);
      end

      $display("[TB] zero-wait write latency");
      startReq(1'b1, 32'h0, 32'hA5A5_0001);
      checkOutput("zw_awaddr", AWADDR, 32'h0);
      checkOutput("zw_wdata", WDATA, 32'hA5A5_0001);
      checkOutput("zw_aw_w_valid", {30'h0, AWVALID, WVALID}, 32'h3);
      waitRsp(lat, rd, er, leak);
      checkOutput("zw_latency", 32'(lat), 32'd3);
      checkOutput("zw_ready_low", {31'h0, leak}, 32'h0);
      checkOutput("zw_wr_rdata", rd, 32'h0);
      @(negedge ACLK);
      checkOutput("zw_pulse_end", {30'h0, rsp_valid, req_ready}, 32'h1);

      $display("[TB] unaligned address is word-aligned");
      startReq(1'b1, 32'h6, 32'h0000_0BEE);
      checkOutput("al_awaddr", AWADDR, 32'h4);
      waitRsp(lat, rd, er, leak);
      applyStimulus(1'b0, 32'h4, 32'h0, lat, rd, er, leak);
      checkOutput("al_readback", rd, 32'h0000_0BEE);

      $display("[TB] AWREADY delayed three cycles");
      aw_delay = 3;
      b0 = bready_cnt;
      startReq(1'b1, 32'hC, 32'h0000_0055);
      checkOutput("dl_c1", {30'h0, AWVALID, WVALID}, 32'h3);
      @(negedge ACLK);
      checkOutput("dl_c2", {29'h0, AWVALID, WVALID, BREADY}, 32'h4);
      @(negedge ACLK);
      checkOutput("dl_c3", {30'h0, AWVALID, WVALID}, 32'h2);
      @(negedge ACLK);
      checkOutput("dl_c4", {30'h0, AWVALID, WVALID}, 32'h2);
      waitRsp(lat, rd, er, leak);
      checkOutput("dl_latency", 32'(lat), 32'd3);
      checkOutput("dl_bready_phases", 32'(bready_cnt - b0), 32'd1);
      checkOutput("dl_err", {31'h0, er}, 32'h0);
      aw_delay = 0;

      $display("[TB] read with SLVERR and write with DECERR");
      rresp_cfg = 2'b10; rdata_force = 1'b1; rdata_val = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 32'h8, 32'h0, lat, rd, er, leak);
      checkOutput("slv_rdata", rd, 32'hDEAD_BEEF);
      checkOutput("slv_err", {31'h0, er}, 32'h1);
      @(negedge ACLK);
      checkOutput("slv_hold", rsp_rdata, 32'hDEAD_BEEF);
      rresp_cfg = 2'b00; rdata_force = 1'b0;
      bresp_cfg = 2'b11;
      applyStimulus(1'b1, 32'h0, 32'h1234_5678, lat, rd, er, leak);
      checkOutput("dec_err", {31'h0, er}, 32'h1);
      checkOutput("dec_rdata", rd, 32'h0);
      bresp_cfg = 2'b00;

      $display("[TB] reset while waiting for ARREADY");
      ar_block = 1'b1;
      startReq(1'b0, 32'h4, 32'h0);
      checkOutput("rr_arvalid", {31'h0, ARVALID}, 32'h1);
      @(negedge ACLK);
      #2 ARESETN = 1'b0;
      #1;
      checkOutput("rr_arvalid_drop", {31'h0, ARVALID}, 32'h0);
      checkOutput("rr_idle", {30'h0, req_ready, rsp_valid}, 32'h2);
      checkOutput("rr_rsp_clear", {rsp_rdata[30:0], rsp_err}, 32'h0);
      @(negedge ACLK);
      ar_block = 1'b0;
      ARESETN = 1'b1;
      applyStimulus(1'b0, 32'hC, 32'h0, lat, rd, er, leak);
      checkOutput("rr_after", rd, 32'h0000_0055);

`ifdef AXIL_BRIDGE_RANGE_CHECK_EN
      $display("[TB] out-of-range read");
      a0 = arvalid_cnt;
      applyStimulus(1'b0, 32'h100, 32'h0, lat, rd, er, leak);
      checkOutput("oor_latency", 32'(lat), 32'd1);
      checkOutput("oor_err", {31'h0, er}, 32'h1);
      checkOutput("oor_rdata", rd, 32'h0);
      checkOutput("oor_no_ar", 32'(arvalid_cnt - a0), 32'd0);
`else
      $display("[TB] high address passes through to AXI");
      a0 = arvalid_cnt;
      applyStimulus(1'b0, 32'h100, 32'h0, lat, rd, er, leak);
      checkOutput("hi_latency", 32'(lat), 32'd3);
      checkOutput("hi_err", {31'h0, er}, 32'h0);
      checkOutput("hi_ar_cycles", 32'(arvalid_cnt - a0), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
